// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - mode encodings shared by the universal shift register
package dff_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/dff_en_cell.sv
// rtl/dff_en_cell.sv - 1-bit DFF with enable, sync reset and complementary outputs
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, loads RST_VAL, overrides en
//   en    clock enable; state holds when low
//   d     next-state data
//   q     registered bit
//   q_bar complement of q
module dff_en_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/dff_shift_reg.sv
// rtl/dff_shift_reg.sv - WIDTH-bit universal shift register with saturating shift counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over en/mode)
//   en        clock enable for all state
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d         parallel load data
//   sin_r     serial in at MSB on shift right (unused when ROTATE=1)
//   sin_l     serial in at LSB on shift left  (unused when ROTATE=1)
//   q         register contents
//   q_bar     ~q
//   sout_r    q[0]
//   sout_l    q[WIDTH-1]
//   shift_cnt shifts since last load/reset, saturating at WIDTH
//   cnt_sat   shift_cnt == WIDTH
module dff_shift_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter bit               ROTATE  = 1'b0,
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic             fill_r;
    logic             fill_l;

    // In rotate mode the outgoing bit re-enters at the opposite end and the
    // serial inputs are never selected, so they cannot leak X into q.
    assign fill_r = ROTATE ? q[0]       : sin_r;
    assign fill_l = ROTATE ? q[WIDTH-1] : sin_l;

    // Hold recirculates q rather than muxing in d/sin, keeping X on those
    // inputs out of the register while idle.
    always_comb begin
        q_next = q;
        case (mode_t'(mode))
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {fill_r, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], fill_l};
            MODE_LOAD: q_next = d;
            default:   q_next = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .d     (q_next[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_SHR, MODE_SHL: begin
                    if (shift_cnt != CNT_MAX) begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                MODE_LOAD: shift_cnt <= '0;
                default:   shift_cnt <= shift_cnt;
            endcase
        end
    end

    assign sout_r  = q[0];
    assign sout_l  = q[WIDTH-1];
    assign cnt_sat = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_dff_shift_reg.sv
// tb/tb_dff_shift_reg.sv - directed self-checking bench for dff_shift_reg
module tb_dff_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       sin_r;
    logic       sin_l;

    logic [3:0] q,     q_rot;
    logic [3:0] q_bar, q_bar_rot;
    logic       sout_r, sout_r_rot;
    logic       sout_l, sout_l_rot;
    logic [2:0] shift_cnt, shift_cnt_rot;
    logic       cnt_sat, cnt_sat_rot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_shift_reg #(.WIDTH(4), .RST_VAL(4'b0000), .ROTATE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
        .q(q), .q_bar(q_bar), .sout_r(sout_r), .sout_l(sout_l),
        .shift_cnt(shift_cnt), .cnt_sat(cnt_sat)
    );

    dff_shift_reg #(.WIDTH(4), .RST_VAL(4'b0000), .ROTATE(1'b1)) u_rot (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
        .q(q_rot), .q_bar(q_bar_rot), .sout_r(sout_r_rot), .sout_l(sout_l_rot),
        .shift_cnt(shift_cnt_rot), .cnt_sat(cnt_sat_rot)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] val);
        en = 1'b1; mode = 2'b11; d = val;
        tick();
    endtask

    logic [3:0] shr_q   [4] = '{4'hD, 4'hE, 4'hF, 4'hF};
    logic       shr_out [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] rol_q   [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b11; d = 4'hF; sin_r = 1'b0; sin_l = 1'b0;
        #1;
        tick(); tick();
        check("rst_q",      q, 4'h0);
        check("rst_q_bar",  q_bar, 4'hF);
        check("rst_cnt",    shift_cnt, 0);
        check("rst_sat",    cnt_sat, 0);
        check("rst_sout_r", sout_r, 0);
        check("rst_sout_l", sout_l, 0);

        // Load then hold
        rst = 1'b0;
        load(4'hA);
        check("load_q", q, 4'hA);
        mode = 2'b00; d = 4'h3; sin_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q",     q, 4'hA);
            check("hold_q_bar", q_bar, 4'h5);
            check("hold_cnt",   shift_cnt, 0);
        end

        // Shift right with serial fill
        load(4'hA);
        mode = 2'b01; sin_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("shr_sout_r", sout_r, shr_out[i]);
            tick();
            check("shr_q",   q, shr_q[i]);
            check("shr_cnt", shift_cnt, i + 1);
            check("shr_sat", cnt_sat, (i == 3) ? 1 : 0);
        end
        tick();
        check("shr5_q",   q, 4'hF);
        check("shr5_cnt", shift_cnt, 4);
        check("shr5_sat", cnt_sat, 1);

        // Shift left with serial fill (non-rotating instance)
        load(4'h9);
        mode = 2'b10; sin_l = 1'b1;
        check("shl_sout_l", sout_l, 1);
        tick();
        check("shl_q",   q, 4'h3);
        check("shl_cnt", shift_cnt, 1);

        // Rotate left: sin_l must be ignored
        load(4'h8);
        check("rol_load_cnt", shift_cnt_rot, 0);
        mode = 2'b10; sin_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rol_q",   q_rot, rol_q[i]);
            check("rol_cnt", shift_cnt_rot, i + 1);
        end
        check("rol_sat", cnt_sat_rot, 1);

        // Enable gating, including unknown inputs while disabled
        load(4'h6);
        en = 1'b0; mode = 2'b01; sin_r = 1'bx; d = 4'bxxxx;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en0_q",   q, 4'h6);
            check("en0_cnt", shift_cnt, 0);
        end
        en = 1'b1; mode = 2'b00;
        tick();
        check("hold_x_q", q, 4'h6);

        // Reset mid-sequence, concurrent with a load request
        load(4'h6);
        mode = 2'b01; sin_r = 1'b0;
        tick(); tick();
        check("mid_q",   q, 4'h1);
        check("mid_cnt", shift_cnt, 2);
        rst = 1'b1; mode = 2'b11; d = 4'hF;
        tick();
        check("mid_rst_q",   q, 4'h0);
        check("mid_rst_cnt", shift_cnt, 0);
        rst = 1'b0; mode = 2'b01; sin_r = 1'b1;
        tick();
        check("restart_q",   q, 4'h8);
        check("restart_cnt", shift_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_shift_reg.md
Name: dff_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal register with complementary outputs.
- Modes: hold, shift right, shift left, parallel load; optional rotate instead of serial fill.
- Saturating shift counter reports how many bits have been shifted since the last load or reset; used as serialiser/deserialiser front end and general pipeline storage.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- ROTATE, 0, 1 = shifts recirculate the outgoing bit; sin_l/sin_r ignored.
- CNT_W, $clog2(WIDTH+1), shift counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; when 0, all state holds regardless of mode.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial in at MSB during shift right.
- sin_l  input  1  serial in at LSB during shift left.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q, always ~q.
- sout_r  output  1  q[0], bit leaving on shift right.
- sout_l  output  1  q[WIDTH-1], bit leaving on shift left.
- shift_cnt  output  CNT_W  shifts since last load/reset, saturating at WIDTH.
- cnt_sat  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Single clock domain; all state updates on posedge clk only. Reset is synchronous, active-high, and has priority over en and mode.
- Reset values: q = RST_VAL, q_bar = ~RST_VAL, shift_cnt = 0, cnt_sat = 0, sout_r = RST_VAL[0], sout_l = RST_VAL[WIDTH-1].
- Latency: one cycle; inputs sampled at edge N appear on q after edge N.
- en=0: q and shift_cnt hold for every mode value.
- en=1, mode 00: hold; counter holds.
- en=1, mode 01: q <= {in, q[WIDTH-1:1]}, in = ROTATE ? q[0] : sin_r.
- en=1, mode 10: q <= {q[WIDTH-2:0], in}, in = ROTATE ? q[WIDTH-1] : sin_l.
- en=1, mode 11: q <= d; shift_cnt <= 0.
- Counter: +1 on each enabled shift (01 or 10), saturates at WIDTH (no wrap). Left and right shifts count equally.
- q_bar, sout_r, sout_l and cnt_sat are combinational decodes of registered state: no extra latency, no glitch-sensitive logic.
- Reset asserted mid-shift sequence discards progress; the next cycle restarts from RST_VAL with count 0.
- Reset and load in the same cycle: reset wins.
- No X propagation from d/sin_* while in hold or while en=0.

Decomposition:
- Shared package dff_pkg holds the mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, plus typedef mode_t.
- One natural sub-module, dff_en_cell: a 1-bit DFF with enable, synchronous reset, reset value, and q/q_bar outputs. Instantiate it WIDTH times via generate. The next-state mux and the counter stay in the top module.

Test Plan (WIDTH=4, RST_VAL=4'b0000, ROTATE=0 unless noted):
- Reset: rst=1 for 2 cycles with d=4'hF, mode=11, en=1 -> q=0000, q_bar=1111, shift_cnt=0, cnt_sat=0.
- Load then hold: mode=11, d=1010, 1 cycle; then mode=00 for 3 cycles -> q=1010 the cycle after load and stays there; q_bar=0101; shift_cnt=0.
- Shift right serial: load 1010, then mode=01, sin_r=1 for 4 cycles -> q=1101, 1110, 1111, 1111; sout_r sequence 0,1,0,1 before each edge; shift_cnt=1..4; cnt_sat=1 after the 4th shift, still 4 after a 5th shift.
- Rotate left (ROTATE=1): load 1000, mode=10 for 4 cycles with sin_l=0 -> q=0001, 0010, 0100, 1000; sin_l ignored.
- Enable gating: load 0110, en=0, mode=01 for 3 cycles -> q stays 0110, shift_cnt stays 0.
- Reset mid-operation: after 2 shifts (shift_cnt=2), assert rst together with mode=11, d=1111 -> q=0000, shift_cnt=0 next cycle.
